pwd_attempt_scheduler: RTL and testbench
========================================

PWD_ATTEMPT_SCHEDULER -- requirements
Module: pwd_attempt_scheduler

Interface
REQ-001 Parameter PWD_LEN, 4, bits per password attempt, sent MSB first.
REQ-002 Parameter FAIL_LIMIT, 3, consecutive failed attempts that trigger lockout.
REQ-003 Parameter LOCKOUT_CYCLES, 16, lockout duration in clk cycles.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req0_valid / req1_valid  in  1 each  requester N has a password attempt pending.
REQ-007 req0_code / req1_code  in  PWD_LEN each  attempt from requester N.
REQ-008 req0_ready / req1_ready  out  1 each  one-cycle pulse; attempt N accepted this cycle.
REQ-009 chk_valid  out  1  serial bit valid toward the bit-serial password checker.
REQ-010 chk_data  out  1  serial bit toward the checker.
REQ-011 chk_ready  in  1  checker idle/ready; sampled only in IDLE.
REQ-012 chk_unlock  in  1  checker verdict: password correct (Mealy, same cycle as bit).
REQ-013 chk_incorrect  in  1  checker verdict: password wrong (Mealy, same cycle as bit).
REQ-014 result_valid  out  1  one-cycle pulse; attempt finished.
REQ-015 result_unlock  out  1  qualified by result_valid; 1 = success, 0 = fail.
REQ-016 result_id  out  1  qualified by result_valid; requester that owned the attempt.
REQ-017 locked_out  out  1  high for the whole lockout period.
REQ-018 fail_count  out  2  current consecutive-failure count.

Function
REQ-019 States SHALL be IDLE, SHIFT, RESULT, LOCKOUT.
REQ-020 IDLE: if any reqN_valid and chk_ready, grant one, load its code into a shift register, pulse reqN_ready, clear the bit index, then go to SHIFT; otherwise stay in IDLE.
REQ-021 Arbitration: if only one request is valid, it is granted; if both are valid, the requester not granted last time wins. After reset, req0 wins the first tie.
REQ-022 SHIFT: chk_valid=1 and chk_data=current MSB of the shift register, every cycle, with no stall.
REQ-023 SHIFT verdict priority:
  - chk_incorrect=1 -> fail; abort remaining bits.
  - else chk_unlock=1 -> success.
  - else bit index == PWD_LEN-1 -> fail (no verdict).
  - else shift left and increment the index.
  - On fail or success, go to RESULT.
REQ-024 chk_incorrect and chk_unlock both high SHALL be treated as fail.
REQ-025 RESULT: single cycle; result_valid=1, result_unlock and result_id registered from the attempt; chk_valid=0.
REQ-026 On success in RESULT: fail_count <= 0, next state IDLE.
REQ-027 On fail in RESULT: fail_count+1. If that value reaches FAIL_LIMIT: fail_count <= 0, load the lockout counter with LOCKOUT_CYCLES, go to LOCKOUT. Otherwise go to IDLE.
REQ-028 LOCKOUT: locked_out=1; the counter decrements each cycle; go to IDLE in the cycle after the counter reads 1; no reqN_ready is asserted.
REQ-029 Latency: accept at cycle T, bits at T+1..T+PWD_LEN, result_valid one cycle after the verdict cycle.
REQ-030 reqN_ready SHALL never be asserted in any state other than IDLE, and at most one reqN_ready is high per cycle.

Reset
REQ-031 On reset_n low, asynchronously:
  - state = IDLE;
  - all outputs = 0;
  - fail_count = 0;
  - lockout counter = 0;
  - arbitration pointer = favour req0.
REQ-032 Reset mid-SHIFT or mid-LOCKOUT SHALL drop the attempt with no result_valid, and drop chk_valid immediately.

Structure
REQ-033 Package pwd_sched_pkg SHALL hold the state enum, PWD_LEN, FAIL_LIMIT, LOCKOUT_CYCLES and the counter-width constants.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter_2 (2 requests, grant, advance-pointer input).

Verification
REQ-035 req0 code 4'b1011, checker ready -> req0_ready at T; chk_data 1,0,1,1 at T+1..T+4; chk_unlock at T+4; result_valid/unlock=1/id=0 at T+5.
REQ-036 req1 code 4'b0011 -> chk_incorrect at T+1; only one bit sent; result_valid unlock=0 id=1 at T+2; fail_count=1.
REQ-037 Both requesters valid continuously -> grants alternate 0,1,0,1.
REQ-038 Three consecutive failures -> locked_out high for exactly 16 cycles; no reqN_ready during lockout; fail_count=0; next request is accepted on the first IDLE cycle.
REQ-039 Two failures then a 1011 success -> fail_count returns to 0; no lockout.
REQ-040 reset_n pulsed low at the 2nd SHIFT bit -> chk_valid=0 immediately; no result_valid; the next attempt completes normally.

Source files
------------

// File: rtl/pwd_sched_pkg.sv
// pwd_sched_pkg: shared constants, state encoding and width helper for the password attempt scheduler.
package pwd_sched_pkg;
    function automatic int cw(input int n);
        return n < 2 ? 1 : $clog2(n + 1);
    endfunction
    localparam int PWD_LEN = 4;
    localparam int FAIL_LIMIT = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int IDX_W = cw(PWD_LEN - 1);
    localparam int FAIL_W = cw(FAIL_LIMIT);
    localparam int LOCK_W = cw(LOCKOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, SHIFT, RESULT, LOCKOUT} state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr;
    assign grant = &req ? (ptr ? 2'b10 : 2'b01) : req;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr <= 1'b0;
        else if (advance) ptr <= grant[0];
    end
endmodule

// File: rtl/pwd_attempt_scheduler.sv
// pwd_attempt_scheduler: arbitrates two requesters, streams the granted code MSB first to a
// bit-serial checker and enforces a lockout after consecutive failures.
module pwd_attempt_scheduler #(
    parameter int PWD_LEN = pwd_sched_pkg::PWD_LEN,
    parameter int FAIL_LIMIT = pwd_sched_pkg::FAIL_LIMIT,
    parameter int LOCKOUT_CYCLES = pwd_sched_pkg::LOCKOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    input  logic [PWD_LEN-1:0] req0_code,
    input  logic [PWD_LEN-1:0] req1_code,
    output logic               req0_ready,
    output logic               req1_ready,
    output logic               chk_valid,
    output logic               chk_data,
    input  logic               chk_ready,
    input  logic               chk_unlock,
    input  logic               chk_incorrect,
    output logic               result_valid,
    output logic               result_unlock,
    output logic               result_id,
    output logic               locked_out,
    output logic [1:0]         fail_count
);
    import pwd_sched_pkg::*;
    localparam int IW = cw(PWD_LEN - 1);
    localparam int LW = cw(LOCKOUT_CYCLES);
    state_t state;
    logic [PWD_LEN-1:0] sr;
    logic [IW-1:0] idx;
    logic [LW-1:0] lock_cnt;
    logic [1:0] grant;
    logic go;
    assign go = reset_n && state == IDLE && chk_ready;
    rr_arbiter_2 u_arb (
        .clk(clk),
        .reset_n(reset_n),
        .req({req1_valid & go, req0_valid & go}),
        .advance(|grant),
        .grant(grant)
    );
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign chk_valid = state == SHIFT;
    assign chk_data = chk_valid & sr[PWD_LEN-1];
    assign result_valid = state == RESULT;
    assign locked_out = state == LOCKOUT;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sr <= '0;
            idx <= '0;
            lock_cnt <= '0;
            fail_count <= '0;
            result_unlock <= 1'b0;
            result_id <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    sr <= grant[1] ? req1_code : req0_code;
                    idx <= '0;
                    result_id <= grant[1];
                    state <= SHIFT;
                end
                SHIFT: if (chk_incorrect || chk_unlock || idx == IW'(PWD_LEN - 1)) begin
                    result_unlock <= chk_unlock & ~chk_incorrect;
                    state <= RESULT;
                end else begin
                    sr <= sr << 1;
                    idx <= idx + 1'b1;
                end
                RESULT: if (result_unlock) begin
                    fail_count <= '0;
                    state <= IDLE;
                end else if (fail_count == 2'(FAIL_LIMIT - 1)) begin
                    fail_count <= '0;
                    lock_cnt <= LW'(LOCKOUT_CYCLES);
                    state <= LOCKOUT;
                end else begin
                    fail_count <= fail_count + 1'b1;
                    state <= IDLE;
                end
                LOCKOUT: begin
                    lock_cnt <= lock_cnt - 1'b1;
                    if (lock_cnt == LW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwd_attempt_scheduler.sv
// tb_pwd_attempt_scheduler: scoreboard bench driving scripted checker verdicts and tracking
// arbitration, fail count and lockout with a small reference model.
module tb_pwd_attempt_scheduler;
    logic clk = 1'b0;
    logic reset_n;
    logic req0_valid, req1_valid;
    logic [3:0] req0_code, req1_code;
    logic req0_ready, req1_ready;
    logic chk_valid, chk_data, chk_ready, chk_unlock, chk_incorrect;
    logic result_valid, result_unlock, result_id, locked_out;
    logic [1:0] fail_count;
    int n_chk = 0;
    int n_pass = 0;
    bit exp_ptr = 1'b0;
    int exp_fail = 0;
    bit exp_lock = 1'b0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    pwd_attempt_scheduler dut (
        .clk(clk),
        .reset_n(reset_n),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .req0_code(req0_code),
        .req1_code(req1_code),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .chk_valid(chk_valid),
        .chk_data(chk_data),
        .chk_ready(chk_ready),
        .chk_unlock(chk_unlock),
        .chk_incorrect(chk_incorrect),
        .result_valid(result_valid),
        .result_unlock(result_unlock),
        .result_id(result_id),
        .locked_out(locked_out),
        .fail_count(fail_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) check("spurious_result", 1, 0);
            else begin
                e = sb.pop_front();
                check("res_unlock", int'(result_unlock), int'(e[1]));
                check("res_id", int'(result_id), int'(e[0]));
            end
        end
    end

    // kind: 0 no verdict, 1 incorrect, 2 unlock, 3 both (counts as fail)
    task automatic attempt(input bit v0, input bit v1, input logic [3:0] c0, input logic [3:0] c1,
                           input int vpos, input int kind, input bit hold);
        bit w;
        bit fail;
        int last;
        logic [3:0] code;
        w = (v0 && v1) ? exp_ptr : v1;
        code = w ? c1 : c0;
        req0_valid = v0;
        req1_valid = v1;
        req0_code = c0;
        req1_code = c1;
        chk_ready = 1'b1;
        #1;
        check("ready0", int'(req0_ready), int'(!w));
        check("ready1", int'(req1_ready), int'(w));
        exp_ptr = !w;
        fail = !(kind == 2 && vpos >= 0);
        sb.push_back({!fail, w});
        last = vpos >= 0 ? vpos : 3;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            chk_unlock = (i == vpos) && (kind == 2 || kind == 3);
            chk_incorrect = (i == vpos) && (kind == 1 || kind == 3);
            #1;
            check("chk_valid", int'(chk_valid), 1);
            check("chk_data", int'(chk_data), int'(code[3-i]));
            check("ready_in_shift", int'(req0_ready | req1_ready), 0);
        end
        @(negedge clk);
        chk_unlock = 1'b0;
        chk_incorrect = 1'b0;
        #1;
        check("result_valid", int'(result_valid), 1);
        check("chk_valid_result", int'(chk_valid), 0);
        check("ready_in_result", int'(req0_ready | req1_ready), 0);
        if (fail) begin
            exp_fail++;
            exp_lock = exp_fail == 3;
            if (exp_lock) exp_fail = 0;
        end else begin
            exp_fail = 0;
            exp_lock = 1'b0;
        end
        @(negedge clk);
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        #1;
        check("fail_count", int'(fail_count), exp_fail);
        check("locked_out", int'(locked_out), int'(exp_lock));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_code = 4'b1111;
        req1_code = 4'b0000;
        chk_ready = 1'b1;
        chk_unlock = 1'b0;
        chk_incorrect = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0", int'(req0_ready), 0);
        check("rst_chk_valid", int'(chk_valid), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_locked", int'(locked_out), 0);
        check("rst_fail", int'(fail_count), 0);
        req0_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        attempt(1, 0, 4'b1011, 4'b0000, 3, 2, 0);
        attempt(0, 1, 4'b0000, 4'b0011, 0, 1, 0);
        req0_valid = 1'b1;
        chk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("ready_chk_busy", int'(req0_ready), 0);
            @(negedge clk);
        end
        attempt(1, 0, 4'b0110, 4'b0000, -1, 0, 0);
        attempt(0, 1, 4'b0000, 4'b1001, 1, 3, 0);
        req0_valid = 1'b1;
        req0_code = 4'b1011;
        for (int i = 0; i < 16; i++) begin
            check("lock_high", int'(locked_out), 1);
            check("lock_no_ready", int'(req0_ready | req1_ready), 0);
            @(negedge clk);
            #1;
        end
        check("lock_end", int'(locked_out), 0);
        attempt(1, 0, 4'b1011, 4'b0000, 3, 2, 0);
        attempt(1, 0, 4'b0101, 4'b0000, 2, 1, 0);
        attempt(0, 1, 4'b0000, 4'b1110, -1, 0, 0);
        attempt(1, 0, 4'b1011, 4'b0000, 3, 2, 0);
        attempt(0, 1, 4'b0000, 4'b0111, 0, 1, 0);
        req0_valid = 1'b1;
        req0_code = 4'b1011;
        #1 check("rst_t_ready", int'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1 check("rst_t_bit0", int'(chk_data), 1);
        @(negedge clk);
        #1 check("rst_t_bit1_valid", int'(chk_valid), 1);
        reset_n = 1'b0;
        #1;
        check("rst_t_chk_valid", int'(chk_valid), 0);
        check("rst_t_fail", int'(fail_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 1'b0;
        exp_fail = 0;
        exp_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 check("rst_t_no_result", int'(result_valid), 0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            check("alt_model", int'(exp_ptr), i % 2);
            attempt(1, 1, 4'b1100, 4'b0101, 0, i % 2 == 0 ? 2 : 1, i != 3);
        end
        attempt(1, 0, 4'b1011, 4'b0000, 3, 2, 0);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
